// File: rtl/psum_writeback_pkg.sv
// Shared types and constants for the psum writeback path (OFIFO reader -> psum SRAM writer).
// These constants are shared with the corelet and SRAM wrappers.
package psum_writeback_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned COL     = 8;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned ROW_W   = PSUM_BW * COL;

    typedef logic [PSUM_BW-1:0]          psum_t;
    typedef logic [COL-1:0][PSUM_BW-1:0] psum_row_t;
    typedef logic [ADDR_W-1:0]           addr_t;
    typedef logic [LEN_W-1:0]            len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

    // One SRAM write-port beat; cen/wen are active-low
    typedef struct packed {
        logic      cen;
        logic      wen;
        addr_t     a;
        psum_row_t d;
    } mem_req_t;

    localparam mem_req_t MEM_IDLE = '{cen: 1'b1, wen: 1'b1, a: '0, d: '0};

    // SRAM addresses wrap modulo 2**ADDR_W
    function automatic addr_t addr_inc(input addr_t a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/psum_writeback_if.sv
// OFIFO read side and psum SRAM write port of the writeback block.
// master = the writeback block, slave = OFIFO/SRAM environment.
interface psum_writeback_if;

    logic                            ofifo_o_valid;
    psum_writeback_pkg::psum_row_t   ofifo_out;
    logic                            ofifo_rd;
    logic                            mem_cen;
    logic                            mem_wen;
    psum_writeback_pkg::addr_t       mem_a;
    psum_writeback_pkg::psum_row_t   mem_d;

    modport master (
        input  ofifo_o_valid,
        input  ofifo_out,
        output ofifo_rd,
        output mem_cen,
        output mem_wen,
        output mem_a,
        output mem_d
    );

    modport slave (
        output ofifo_o_valid,
        output ofifo_out,
        input  ofifo_rd,
        input  mem_cen,
        input  mem_wen,
        input  mem_a,
        input  mem_d
    );

endinterface

// File: rtl/psum_writeback_relu_col.sv
// wb_relu_col: per-column clamp of negative partial sums to zero.
// Only present when PSUM_WB_RELU_EN is defined.
`ifdef PSUM_WB_RELU_EN
module wb_relu_col
    import psum_writeback_pkg::*;
(
    input  psum_t psum_in,
    output psum_t psum_out
);

    assign psum_out = psum_in[PSUM_BW-1] ? '0 : psum_in;

endmodule
`endif

// File: rtl/psum_writeback.sv
// psum_writeback: drains OFIFO rows into consecutive psum SRAM addresses, one write per pop.
// Build option PSUM_WB_RELU_EN clamps negative columns to zero at capture.
module psum_writeback
    import psum_writeback_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  addr_t  base_addr,
    input  len_t   num_rows,
    output logic   busy,
    output logic   done,
    psum_writeback_if.master bus
);

    wb_state_t state;
    addr_t     addr_q;
    len_t      rem_q;
    mem_req_t  mem_q;
    psum_row_t row_in;
    logic      pop;

    // Pop whenever a row is offered and rows remain; the write follows one cycle later
    assign pop          = (state == ST_DRAIN) && bus.ofifo_o_valid && (rem_q != '0);
    assign bus.ofifo_rd = pop;

`ifdef PSUM_WB_RELU_EN
    for (genvar c = 0; c < COL; c++) begin : g_relu
        wb_relu_col u_relu (
            .psum_in  (bus.ofifo_out[c]),
            .psum_out (row_in[c])
        );
    end
`else
    assign row_in = bus.ofifo_out;
`endif

    assign bus.mem_cen = mem_q.cen;
    assign bus.mem_wen = mem_q.wen;
    assign bus.mem_a   = mem_q.a;
    assign bus.mem_d   = mem_q.d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            mem_q  <= MEM_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            mem_q.cen <= 1'b1;
            mem_q.wen <= 1'b1;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= num_rows;
                        busy   <= 1'b1;
                        // An empty job still passes through FLUSH so done lands 2 cycles after start
                        state  <= (num_rows == '0) ? ST_FLUSH : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop) begin
                        mem_q.cen <= 1'b0;
                        mem_q.wen <= 1'b0;
                        mem_q.a   <= addr_q;
                        mem_q.d   <= row_in;
                        addr_q    <= addr_inc(addr_q);
                        rem_q     <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: directed spec scenarios plus randomized jobs
// checked cycle-by-cycle against a job-level reference model.
module tb_psum_writeback;
    import psum_writeback_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  start = 1'b0;
    addr_t base_addr = '0;
    len_t  num_rows = '0;
    logic  busy;
    logic  done;

    int n_tests = 0;
    int n_fail  = 0;

    psum_writeback_if bus ();

    psum_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic psum_row_t model_row(input psum_row_t r);
        psum_row_t o;
        o = r;
`ifdef PSUM_WB_RELU_EN
        for (int c = 0; c < COL; c++) begin
            if (o[c][PSUM_BW-1]) o[c] = '0;
        end
`endif
        return o;
    endfunction

    function automatic psum_row_t rand_row();
        psum_row_t r;
        for (int c = 0; c < COL; c++) r[c] = PSUM_BW'($urandom);
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"},   ROW_W'(bus.ofifo_rd), '0);
        check({tag, "_cen"},  ROW_W'(bus.mem_cen), ROW_W'(1));
        check({tag, "_wen"},  ROW_W'(bus.mem_wen), ROW_W'(1));
        check({tag, "_busy"}, ROW_W'(busy), '0);
        check({tag, "_done"}, ROW_W'(done), '0);
    endtask

    // mode: 0 valid always high, 1 valid pattern 1,0,0,1,1 then high, 2 random valid + stray starts,
    //       3 valid high with a fixed sign-mixed first row
    task automatic run_job(input string tag, input addr_t base, input int num, input int mode);
        psum_row_t rows[$];
        int        pops = 0;
        int        last = -1;
        int        wr_idx = 0;
        logic      prev_pop = 1'b0;
        logic      finished = 1'b0;
        logic      valid_now;
        logic      exp_rd, exp_busy, exp_done;
        int        pattern[5] = '{1, 0, 0, 1, 1};
        psum_row_t r;

        for (int i = 0; i < num; i++) begin
            r = rand_row();
            if (mode == 3 && i == 0) begin
                r[0] = 16'hFFF0;
                r[1] = 16'h0005;
            end
            rows.push_back(r);
        end
        if (num == 0) last = 0;

        start     = 1'b1;
        base_addr = base;
        num_rows  = LEN_W'(num);
        bus.ofifo_o_valid = 1'($urandom);
        bus.ofifo_out     = (num > 0) ? rows[0] : rand_row();

        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            valid_now = bus.ofifo_o_valid;
            exp_rd    = (c >= 1) && valid_now && (pops < num);
            exp_busy  = (c >= 1) && ((pops < num) || (c == last + 1));
            exp_done  = (c >= 1) && (last >= 0) && (c == last + 2);

            check({tag, "_rd"},   ROW_W'(bus.ofifo_rd), ROW_W'(exp_rd));
            check({tag, "_cen"},  ROW_W'(bus.mem_cen), ROW_W'(!prev_pop));
            check({tag, "_wen"},  ROW_W'(bus.mem_wen), ROW_W'(!prev_pop));
            check({tag, "_busy"}, ROW_W'(busy), ROW_W'(exp_busy));
            check({tag, "_done"}, ROW_W'(done), ROW_W'(exp_done));
            if (prev_pop) begin
                check({tag, "_addr"}, ROW_W'(bus.mem_a), ROW_W'(addr_t'(base + ADDR_W'(wr_idx))));
                check({tag, "_data"}, bus.mem_d, model_row(rows[wr_idx]));
                wr_idx++;
            end

            prev_pop = exp_rd;
            if (exp_rd) begin
                pops++;
                if (pops == num) last = c;
            end
            if (exp_done) finished = 1'b1;

            @(posedge clk);
            #1;
            start = 1'b0;
            // Stray starts while the job is running must not disturb it
            if (mode == 2 && ((pops < num) || (c + 1 == last + 1)) && ($urandom_range(0, 7) == 0)) begin
                start     = 1'b1;
                base_addr = addr_t'($urandom);
                num_rows  = LEN_W'($urandom_range(0, 20));
            end
            case (mode)
                1:       bus.ofifo_o_valid = (c < 5) ? 1'(pattern[c]) : 1'b1;
                2:       bus.ofifo_o_valid = ($urandom_range(0, 2) != 0);
                default: bus.ofifo_o_valid = 1'b1;
            endcase
            bus.ofifo_out = (pops < num) ? rows[pops] : rand_row();
        end
        check({tag, "_finished"}, ROW_W'(finished), ROW_W'(1));
        check({tag, "_nwrites"},  ROW_W'(wr_idx), ROW_W'(num));
        start = 1'b0;
    endtask

    initial begin
        bus.ofifo_o_valid = 1'b0;
        bus.ofifo_out     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr", ROW_W'(bus.mem_a), '0);
        check("reset_data", bus.mem_d, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_job("stream", 11'h010, 4, 0);
        run_job("stall",  11'h020, 3, 1);
        run_job("wrap",   11'h7FE, 3, 0);
        run_job("zero",   11'h123, 0, 0);
        run_job("relu",   11'h040, 2, 3);

        // Reset during DRAIN after two pops aborts with no further activity
        start = 1'b1;
        base_addr = 11'h100;
        num_rows  = LEN_W'(6);
        bus.ofifo_o_valid = 1'b1;
        bus.ofifo_out     = rand_row();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            bus.ofifo_out = rand_row();
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        check("abort_addr", ROW_W'(bus.mem_a), '0);
        check("abort_data", bus.mem_d, '0);
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("abort_idle");
        end
        @(posedge clk);
        #1;

        for (int j = 0; j < 25; j++) begin
            run_job("rand", addr_t'($urandom), $urandom_range(0, 12), 2);
            if ($urandom_range(0, 1) == 1) begin
                bus.ofifo_o_valid = 1'b1;
                @(negedge clk);
                check_idle_outputs("gap");
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
